// File: rtl/stack_seq_pkg.sv
// stack_seq_pkg
//   Shared definitions for the interrupt-entry / RTI stack sequencer.
//   Contents:
//     PC_W               width of a program counter value
//     INT_VECTOR_DEFAULT PC loaded on interrupt entry unless overridden
//     CNT_W              width of the drain / pop-latency down-counter
//     state_t            sequencer state encoding
package stack_seq_pkg;

  localparam int PC_W  = 16;
  localparam int CNT_W = 8;

  localparam logic [PC_W-1:0] INT_VECTOR_DEFAULT = 16'h0000;

  typedef enum logic [2:0] {
    IDLE,
    INT_DRAIN,
    INT_PUSH_PC,
    INT_PUSH_CCR,
    INT_REDIRECT,
    RTI_POP_CCR,
    RTI_POP_PC,
    RTI_WAIT
  } state_t;

endpackage

// File: rtl/stack_seq_if.sv
// stack_seq_if
//   Bundle between the stack sequencer and the pipeline around it.
//   Pipeline -> sequencer: int_req, rti_dec, hold, pc_cur, pop_pc_data
//   Sequencer -> pipeline: op_valid, op_pushPc, op_pushCCR, op_popCCR,
//                          op_popPc, op_int1, saved_pc, stall_fetch,
//                          flush_ifid, pc_load, pc_target, busy
//   Modports: slave = the sequencer, master = the pipeline side.
interface stack_seq_if;
  import stack_seq_pkg::*;

  logic            int_req;
  logic            rti_dec;
  logic            hold;
  logic [PC_W-1:0] pc_cur;
  logic [PC_W-1:0] pop_pc_data;

  logic            op_valid;
  logic            op_pushPc;
  logic            op_pushCCR;
  logic            op_popCCR;
  logic            op_popPc;
  logic            op_int1;
  logic [PC_W-1:0] saved_pc;
  logic            stall_fetch;
  logic            flush_ifid;
  logic            pc_load;
  logic [PC_W-1:0] pc_target;
  logic            busy;

  modport slave (
    input  int_req, rti_dec, hold, pc_cur, pop_pc_data,
    output op_valid, op_pushPc, op_pushCCR, op_popCCR, op_popPc, op_int1,
           saved_pc, stall_fetch, flush_ifid, pc_load, pc_target, busy
  );

  modport master (
    output int_req, rti_dec, hold, pc_cur, pop_pc_data,
    input  op_valid, op_pushPc, op_pushCCR, op_popCCR, op_popPc, op_int1,
           saved_pc, stall_fetch, flush_ifid, pc_load, pc_target, busy
  );

endinterface

// File: rtl/stack_seq_ctrl_counter.sv
// seq_wait_counter
//   Loadable down-counter with a freeze input and a zero flag. Shared by the
//   interrupt drain wait and the popped-PC latency wait.
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     hold        freezes the count (load and decrement ignored)
//     load        load load_val this cycle (wins over dec)
//     dec         decrement by one, saturating at zero
//     load_val    value to load
//     zero        count is zero
module seq_wait_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hold,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // Count register: a stalled pipeline must not lose wait cycles, so hold
  // freezes both load and decrement. Saturation keeps a stray dec harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!hold) begin
      if (load) begin
        count <= load_val;
      end else if (dec && (count != '0)) begin
        count <= count - W'(1);
      end
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/stack_seq_ctrl.sv
// stack_seq_ctrl
//   Sequences the stack operations for interrupt entry (drain, push PC,
//   push CCR, redirect to vector) and RTI return (pop CCR, pop PC, wait for
//   the popped PC, redirect). It is the only source of the injected
//   pushPc/pushCCR/popCCR/popPc/int1 bits; it also freezes fetch, flushes
//   IF/ID and issues the PC redirect.
//   Ports:
//     clk    pipeline clock
//     rst_n  asynchronous active-low reset
//     bus    stack_seq_if.slave (requests in, injected ops and PC control out)
//   Parameters: DRAIN_CYCLES, POP_LAT, INT_VECTOR.
//   Build option: define INT_CCR_SAVE_EN to include the CCR push/pop steps;
//   without it the sequences carry only the PC and op_pushCCR/op_popCCR
//   stay 0.
module stack_seq_ctrl
  import stack_seq_pkg::*;
#(
  parameter int              DRAIN_CYCLES = 3,
  parameter int              POP_LAT      = 2,
  parameter logic [PC_W-1:0] INT_VECTOR   = INT_VECTOR_DEFAULT
) (
  input logic        clk,
  input logic        rst_n,
  stack_seq_if.slave bus
);

  // Counter reload values; zero-length waits load 0 so nothing underflows.
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] POP_LOAD   = CNT_W'((POP_LAT > 0) ? POP_LAT - 1 : 0);

  state_t          state, state_next;
  logic            int_pend;
  logic [PC_W-1:0] saved_pc_q;

  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val;
  logic             pend_clr, capture_pc;

  logic            valid_c, push_pc_c, push_ccr_c, pop_ccr_c, pop_pc_c, int1_c;
  logic            stall_c, flush_c, load_c;
  logic [PC_W-1:0] target_c;

  seq_wait_counter #(.W(CNT_W)) u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .hold     (bus.hold),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  // State, pending-interrupt flag and captured return PC. A global hold
  // freezes everything here so the sequence resumes exactly where it was.
  // Clearing the pending flag wins over a request in the same cycle: the
  // request being served is the one that cleared it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      int_pend   <= 1'b0;
      saved_pc_q <= '0;
    end else if (!bus.hold) begin
      state <= state_next;
      if (pend_clr) begin
        int_pend <= 1'b0;
      end else if (bus.int_req) begin
        int_pend <= 1'b1;
      end
      if (capture_pc) begin
        saved_pc_q <= bus.pc_cur;
      end
    end
  end

  // Next-state and raw per-state outputs. RTI has priority in IDLE; an
  // interrupt arriving with it stays pending and is taken after the return.
  // Interrupts are only started from IDLE, which masks them while busy.
  always_comb begin
    state_next = state;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    cnt_val    = '0;
    pend_clr   = 1'b0;
    capture_pc = 1'b0;
    valid_c    = 1'b0;
    push_pc_c  = 1'b0;
    push_ccr_c = 1'b0;
    pop_ccr_c  = 1'b0;
    pop_pc_c   = 1'b0;
    int1_c     = 1'b0;
    stall_c    = 1'b0;
    flush_c    = 1'b0;
    load_c     = 1'b0;
    target_c   = '0;

    case (state)
      IDLE: begin
        if (bus.rti_dec) begin
`ifdef INT_CCR_SAVE_EN
          state_next = RTI_POP_CCR;
`else
          state_next = RTI_POP_PC;
`endif
        end else if (int_pend || bus.int_req) begin
          capture_pc = 1'b1;
          if (DRAIN_CYCLES == 0) begin
            state_next = INT_PUSH_PC;
            pend_clr   = 1'b1;
          end else begin
            state_next = INT_DRAIN;
            cnt_load   = 1'b1;
            cnt_val    = DRAIN_LOAD;
          end
        end
      end

      INT_DRAIN: begin
        stall_c = 1'b1;
        flush_c = 1'b1;
        if (cnt_zero) begin
          state_next = INT_PUSH_PC;
          pend_clr   = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      INT_PUSH_PC: begin
        valid_c   = 1'b1;
        push_pc_c = 1'b1;
        int1_c    = 1'b1;
        stall_c   = 1'b1;
`ifdef INT_CCR_SAVE_EN
        state_next = INT_PUSH_CCR;
`else
        state_next = INT_REDIRECT;
`endif
      end

`ifdef INT_CCR_SAVE_EN
      INT_PUSH_CCR: begin
        valid_c    = 1'b1;
        push_ccr_c = 1'b1;
        int1_c     = 1'b1;
        stall_c    = 1'b1;
        state_next = INT_REDIRECT;
      end

      RTI_POP_CCR: begin
        valid_c    = 1'b1;
        pop_ccr_c  = 1'b1;
        stall_c    = 1'b1;
        flush_c    = 1'b1;
        state_next = RTI_POP_PC;
      end
`endif

      INT_REDIRECT: begin
        load_c     = 1'b1;
        target_c   = INT_VECTOR;
        flush_c    = 1'b1;
        state_next = IDLE;
      end

      RTI_POP_PC: begin
        valid_c    = 1'b1;
        pop_pc_c   = 1'b1;
        stall_c    = 1'b1;
        cnt_load   = 1'b1;
        cnt_val    = POP_LOAD;
        state_next = RTI_WAIT;
      end

      RTI_WAIT: begin
        stall_c = 1'b1;
        if (cnt_zero) begin
          load_c     = 1'b1;
          target_c   = bus.pop_pc_data;
          state_next = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // While held nothing may issue: the op and the redirect are suppressed
  // here and reappear on the first unheld cycle because the state is frozen.
  assign bus.op_valid    = valid_c & ~bus.hold;
  assign bus.op_pushPc   = push_pc_c & bus.op_valid;
  assign bus.op_pushCCR  = push_ccr_c & bus.op_valid;
  assign bus.op_popCCR   = pop_ccr_c & bus.op_valid;
  assign bus.op_popPc    = pop_pc_c & bus.op_valid;
  assign bus.op_int1     = int1_c & bus.op_valid;
  assign bus.stall_fetch = stall_c | bus.hold;
  assign bus.flush_ifid  = flush_c;
  assign bus.pc_load     = load_c & ~bus.hold;
  assign bus.pc_target   = target_c;
  assign bus.saved_pc    = saved_pc_q;
  assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_stack_seq_ctrl.sv
// tb_stack_seq_ctrl
//   Directed bench for stack_seq_ctrl with the default parameters
//   (DRAIN_CYCLES=3, POP_LAT=2, INT_VECTOR=0). Expected control vectors are
//   written out by hand per cycle; INT_CCR_SAVE_EN selects which sequence
//   shape is expected. Control vector bit order:
//   {op_valid, pushPc, pushCCR, popCCR, popPc, int1, stall, flush, pc_load, busy}
module tb_stack_seq_ctrl;

  localparam logic [9:0] V_IDLE    = 10'b0000000000;
  localparam logic [9:0] V_DRAIN   = 10'b0000001101;
  localparam logic [9:0] V_PUSHPC  = 10'b1100011001;
  localparam logic [9:0] V_PUSHCCR = 10'b1010011001;
  localparam logic [9:0] V_REDIR   = 10'b0000000111;
  localparam logic [9:0] V_POPCCR  = 10'b1001001101;
  localparam logic [9:0] V_POPPC   = 10'b1000101001;
  localparam logic [9:0] V_WAIT    = 10'b0000001001;
  localparam logic [9:0] V_WAITLD  = 10'b0000001011;
  localparam logic [9:0] V_HELD    = 10'b0000001001;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  stack_seq_if bus();

  stack_seq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so a stuck run still terminates with a visible failure.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [9:0] ctrl();
    return {bus.op_valid, bus.op_pushPc, bus.op_pushCCR, bus.op_popCCR,
            bus.op_popPc, bus.op_int1, bus.stall_fetch, bus.flush_ifid,
            bus.pc_load, bus.busy};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic applyStimulus(input logic int_req, input logic rti_dec, input logic hold);
    bus.int_req = int_req;
    bus.rti_dec = rti_dec;
    bus.hold    = hold;
  endtask

  // Advance one clock and sample just after the edge.
  task automatic stepCheck(input string tag, input logic [9:0] want);
    @(posedge clk);
    #1;
    checkOutput(tag, {22'd0, ctrl()}, {22'd0, want});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.pc_cur      = 16'h0000;
    bus.pop_pc_data = 16'h0000;
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Power-on reset state
    #1;
    checkOutput("reset_ctrl", {22'd0, ctrl()}, {22'd0, V_IDLE});
    checkOutput("reset_saved_pc", {16'd0, bus.saved_pc}, 32'h0);
    checkOutput("reset_target", {16'd0, bus.pc_target}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    stepCheck("idle_after_reset", V_IDLE);

    // Interrupt entry, 1-cycle int_req pulse
    bus.pc_cur = 16'h0040;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("int_idle", {22'd0, ctrl()}, {22'd0, V_IDLE});
    stepCheck("int_drain0", V_DRAIN);
    applyStimulus(1'b0, 1'b0, 1'b0);
    bus.pc_cur = 16'h1234;
    stepCheck("int_drain1", V_DRAIN);
    stepCheck("int_drain2", V_DRAIN);
    stepCheck("int_pushpc", V_PUSHPC);
    checkOutput("int_saved_pc", {16'd0, bus.saved_pc}, 32'h0040);
`ifdef INT_CCR_SAVE_EN
    stepCheck("int_pushccr", V_PUSHCCR);
`endif
    stepCheck("int_redirect", V_REDIR);
    checkOutput("int_target", {16'd0, bus.pc_target}, 32'h0000);
    stepCheck("int_done", V_IDLE);

    // RTI return
    bus.pop_pc_data = 16'h0041;
    applyStimulus(1'b0, 1'b1, 1'b0);
`ifdef INT_CCR_SAVE_EN
    stepCheck("rti_popccr", V_POPCCR);
    applyStimulus(1'b0, 1'b0, 1'b0);
`endif
    stepCheck("rti_poppc", V_POPPC);
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepCheck("rti_wait", V_WAIT);
    stepCheck("rti_load", V_WAITLD);
    checkOutput("rti_target", {16'd0, bus.pc_target}, 32'h0041);
    stepCheck("rti_done", V_IDLE);

    // RTI and interrupt together: RTI first, interrupt after return
    bus.pc_cur      = 16'h0100;
    bus.pop_pc_data = 16'h0200;
    applyStimulus(1'b1, 1'b1, 1'b0);
`ifdef INT_CCR_SAVE_EN
    stepCheck("both_popccr", V_POPCCR);
    applyStimulus(1'b0, 1'b0, 1'b0);
`endif
    stepCheck("both_poppc", V_POPPC);
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepCheck("both_wait", V_WAIT);
    stepCheck("both_load", V_WAITLD);
    checkOutput("both_target", {16'd0, bus.pc_target}, 32'h0200);
    stepCheck("both_idle", V_IDLE);
    stepCheck("both_drain0", V_DRAIN);
    stepCheck("both_drain1", V_DRAIN);
    stepCheck("both_drain2", V_DRAIN);
    stepCheck("both_pushpc", V_PUSHPC);
    checkOutput("both_saved_pc", {16'd0, bus.saved_pc}, 32'h0100);
`ifdef INT_CCR_SAVE_EN
    stepCheck("both_pushccr", V_PUSHCCR);
`endif
    stepCheck("both_redirect", V_REDIR);
    stepCheck("both_done", V_IDLE);

    // Hold for two cycles while in INT_PUSH_PC
    bus.pc_cur = 16'h0300;
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepCheck("hold_drain0", V_DRAIN);
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepCheck("hold_drain1", V_DRAIN);
    stepCheck("hold_drain2", V_DRAIN);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("hold_cycle0", {22'd0, ctrl()}, {22'd0, V_HELD});
    stepCheck("hold_cycle1", V_HELD);
    applyStimulus(1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("hold_release", {22'd0, ctrl()}, {22'd0, V_PUSHPC});
`ifdef INT_CCR_SAVE_EN
    stepCheck("hold_pushccr", V_PUSHCCR);
`endif
    stepCheck("hold_redirect", V_REDIR);
    stepCheck("hold_done", V_IDLE);

    // Asynchronous reset in the middle of interrupt entry
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepCheck("rst_drain0", V_DRAIN);
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepCheck("rst_drain1", V_DRAIN);
    stepCheck("rst_drain2", V_DRAIN);
    stepCheck("rst_pushpc", V_PUSHPC);
`ifdef INT_CCR_SAVE_EN
    stepCheck("rst_pushccr", V_PUSHCCR);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_ctrl", {22'd0, ctrl()}, {22'd0, V_IDLE});
    checkOutput("rst_async_saved_pc", {16'd0, bus.saved_pc}, 32'h0);
    checkOutput("rst_async_target", {16'd0, bus.pc_target}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stepCheck("rst_released", V_IDLE);
    stepCheck("rst_stays_idle", V_IDLE);

    // Random int/rti/hold traffic with structural invariants
    for (int i = 0; i < 1000; i++) begin
      bus.pc_cur      = 16'($urandom);
      bus.pop_pc_data = 16'($urandom);
      applyStimulus(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 5) == 0));
      @(posedge clk);
      #1;
      checkOutput("rand_onehot",
                  {31'd0, ($countones({bus.op_pushPc, bus.op_pushCCR, bus.op_popCCR, bus.op_popPc}) > 1)},
                  32'd0);
      checkOutput("rand_op_without_valid",
                  {31'd0, (!bus.op_valid && (bus.op_pushPc || bus.op_pushCCR || bus.op_popCCR ||
                                            bus.op_popPc || bus.op_int1))},
                  32'd0);
      if (bus.hold) begin
        checkOutput("rand_hold_quiet", {29'd0, bus.op_valid, bus.pc_load, bus.stall_fetch}, 32'b001);
      end
`ifndef INT_CCR_SAVE_EN
      checkOutput("rand_no_ccr", {30'd0, bus.op_pushCCR, bus.op_popCCR}, 32'd0);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
